os_step_feeder: RTL and testbench
=================================

Name: os_step_feeder

Overview:
- Initiator-side sequencer for the output-stationary MAC array's step interface.
- On a job start it reads A column k and B row k from two single-port read buffers for k = 0..K-1.
- Issues each k as one step with k_first/k_last flags over the step_valid/step_ready handshake.
- After the last step it waits for the array's c_valid pulse, captures the M×N result and streams it out one row per handshake on a valid/ready port.

Parameters:
- M, 8, array rows (A column length, C rows).
- N, 8, array columns (B row length, C row length).
- KW, 16, width of k_len and read addresses.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- start  input  1  job request pulse/level.
- k_len  input  KW  number of K steps; sampled at start.
- busy  output  1  job in progress.
- done  output  1  1-cycle job-complete pulse.
- err  output  1  valid with done; k_len==0 or partial c_valid.
- a_rd_en  output  1  A buffer read strobe.
- a_rd_addr  output  KW  A buffer address (= k).
- a_rd_data  input  M*32  A[:,k]; valid 1 cycle after a_rd_en.
- b_rd_en  output  1  B buffer read strobe.
- b_rd_addr  output  KW  B buffer address (= k).
- b_rd_data  input  N*32  B[k,:]; valid 1 cycle after b_rd_en.
- step_valid  output  1  step offer.
- step_ready  input  1  array accepts step.
- a_row_flat  output  M*32  element i at [i*32+:32].
- b_col_flat  output  N*32  element j at [j*32+:32].
- k_first  output  1  step is k=0.
- k_last  output  1  step is k=K-1.
- c_out_flat  input  M*N*32  result; C[i][j] at [(i*N+j)*32+:32].
- c_valid_flat  input  M*N  per-element result pulse.
- c_row_valid  output  1  result row offer.
- c_row_ready  input  1  result row accept.
- c_row_idx  output  $clog2(M) (min 1)  row index.
- c_row_data  output  N*32  C[row][0..N-1].

Behaviour:
- Reset and clocking:
  - Reset rst, synchronous, active-high; clock clk.
  - All outputs are registered and reset to 0.
  - Internal state resets to S_IDLE; k_cnt, row counter and C buffer reset to 0.
  - Reset mid-job aborts immediately with no done pulse. rst is shared with the array.
- States: S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT_C, S_DRAIN.
- S_IDLE:
  - start with k_len≠0: latch K=k_len, k_cnt=0, busy=1, go to S_FETCH.
  - start with k_len==0: no reads and no steps; next cycle done=1, err=1, stay in S_IDLE.
  - start while busy is ignored.
- S_FETCH:
  - a_rd_en=b_rd_en=1 for exactly this cycle; addr=k_cnt. Go to S_LOAD.
- S_LOAD:
  - Register a_rd_data→a_row_flat and b_rd_data→b_col_flat.
  - k_first=(k_cnt==0), k_last=(k_cnt==K-1).
  - step_valid=1. Go to S_ISSUE.
- S_ISSUE:
  - Hold step_valid and payload stable until step_valid&&step_ready.
  - On handshake, step_valid=0 from the next cycle. It must never remain high in the cycle after a handshake, because the array re-samples when it returns to idle.
  - If k_last: go to S_WAIT_C. Otherwise k_cnt++ and go to S_FETCH.
  - Payload and flags may remain at their last values while step_valid=0.
- S_WAIT_C:
  - First cycle with |c_valid_flat: copy c_out_flat into the C buffer, row=0, go to S_DRAIN.
  - If the pulse is not all ones, set the job err flag.
  - c_valid pulses in any other state are ignored.
- S_DRAIN:
  - c_row_valid=1, c_row_idx=row, c_row_data=buffer[row*N*32+:N*32].
  - Data and index stay stable while c_row_valid&&!c_row_ready.
  - On handshake with row<M-1: row++, valid stays high (back-to-back rows allowed).
  - On handshake with row==M-1: c_row_valid=0, busy=0, done=1 for 1 cycle with err, go to S_IDLE.
- Timing:
  - Minimum per-step cost is 3 feeder cycles (FETCH, LOAD, ISSUE) plus array stall while step_ready=0.
  - No timeout; S_ISSUE and S_WAIT_C wait indefinitely.
- err is sticky for the job and cleared on the next accepted start.

Test Plan:
- M=N=2, K=1, A[:,0]={0x3F800000,0x40000000}, B[0,:]={0x40400000,0x40800000}, array model returns the outer product:
  - Exactly one step with k_first=k_last=1.
  - Rows streamed: 0:{0x40400000,0x40800000}, 1:{0x40C00000,0x41000000}.
  - done=1, err=0.
- K=3, step_ready dropped for 5 cycles after each accept:
  - rd addrs 0,1,2 each a 1-cycle strobe.
  - Exactly 3 handshakes; k_first only on the 1st, k_last only on the 3rd.
  - step_valid=0 in every cycle following a handshake.
- start with k_len=0:
  - No rd_en, no step_valid.
  - done=err=1 one cycle later; busy stays 0.
- c_row_ready low 4 cycles during DRAIN:
  - c_row_idx=0 and c_row_data unchanged throughout.
  - Then 2 rows consumed back-to-back on 2 consecutive ready cycles.
- Control corner cases:
  - rst asserted during S_ISSUE: next cycle step_valid=busy=0 and no done. A following K=1 job completes correctly.
  - start while busy: no effect.
- c_valid handling:
  - c_valid_flat pulse in S_IDLE: ignored, no output activity.
  - c_valid_flat=4'b0111 in S_WAIT_C: captured and drained, done with err=1.

Source files
------------

// File: rtl/os_step_feeder.sv
// Step sequencer for the output-stationary MAC array: fetches A column / B row
// per k, issues steps over a valid/ready handshake, then captures and streams C rows.
module os_step_feeder #(
  parameter int unsigned M  = 8,
  parameter int unsigned N  = 8,
  parameter int unsigned KW = 16,
  localparam int unsigned RW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                a_rd_en,
  output logic [KW-1:0]       a_rd_addr,
  input  logic [M*32-1:0]     a_rd_data,
  output logic                b_rd_en,
  output logic [KW-1:0]       b_rd_addr,
  input  logic [N*32-1:0]     b_rd_data,
  output logic                step_valid,
  input  logic                step_ready,
  output logic [M*32-1:0]     a_row_flat,
  output logic [N*32-1:0]     b_col_flat,
  output logic                k_first,
  output logic                k_last,
  input  logic [M*N*32-1:0]   c_out_flat,
  input  logic [M*N-1:0]      c_valid_flat,
  output logic                c_row_valid,
  input  logic                c_row_ready,
  output logic [RW-1:0]       c_row_idx,
  output logic [N*32-1:0]     c_row_data
);

  localparam int unsigned AW = M * 32;
  localparam int unsigned BW = N * 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT_C,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [KW-1:0]   k_cnt_q, k_cnt_d;
  logic [KW-1:0]   rd_addr_q, rd_addr_d;
  logic            rd_en_q, rd_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            err_job_q, err_job_d;
  logic [AW-1:0]   a_row_q, a_row_d;
  logic [BW-1:0]   b_col_q, b_col_d;
  logic            k_first_q, k_first_d;
  logic            k_last_q, k_last_d;
  logic            step_valid_q, step_valid_d;
  logic [RW-1:0]   row_q, row_d;
  logic            c_row_valid_q, c_row_valid_d;
  logic [BW-1:0]   c_row_data_q, c_row_data_d;
  logic [BW-1:0]   c_buf_q [M];
  logic [BW-1:0]   c_buf_d [M];

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    k_len_d       = k_len_q;
    k_cnt_d       = k_cnt_q;
    rd_addr_d     = rd_addr_q;
    rd_en_d       = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    err_job_d     = err_job_q;
    a_row_d       = a_row_q;
    b_col_d       = b_col_q;
    k_first_d     = k_first_q;
    k_last_d      = k_last_q;
    step_valid_d  = step_valid_q;
    row_d         = row_q;
    c_row_valid_d = c_row_valid_q;
    c_row_data_d  = c_row_data_q;
    c_buf_d       = c_buf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            k_len_d   = k_len;
            k_cnt_d   = '0;
            rd_addr_d = '0;
            rd_en_d   = 1'b1;
            busy_d    = 1'b1;
            err_job_d = 1'b0;
            state_d   = S_FETCH;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end

      S_FETCH: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        a_row_d      = a_rd_data;
        b_col_d      = b_rd_data;
        k_first_d    = (k_cnt_q == '0);
        k_last_d     = (k_cnt_q == k_len_q - KW'(1));
        step_valid_d = 1'b1;
        state_d      = S_ISSUE;
      end

      // Drop step_valid right after the handshake so the array never re-samples it
      S_ISSUE: begin
        if (step_valid_q && step_ready) begin
          step_valid_d = 1'b0;
          if (k_last_q) begin
            state_d = S_WAIT_C;
          end else begin
            k_cnt_d   = k_cnt_q + KW'(1);
            rd_addr_d = k_cnt_q + KW'(1);
            rd_en_d   = 1'b1;
            state_d   = S_FETCH;
          end
        end
      end

      S_WAIT_C: begin
        if (|c_valid_flat) begin
          for (int i = 0; i < M; i++) begin
            c_buf_d[i] = c_out_flat[i*BW +: BW];
          end
          if (c_valid_flat != '1) begin
            err_job_d = 1'b1;
          end
          row_d         = '0;
          c_row_data_d  = c_out_flat[BW-1:0];
          c_row_valid_d = 1'b1;
          state_d       = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (c_row_valid_q && c_row_ready) begin
          if (row_q == RW'(M - 1)) begin
            c_row_valid_d = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            err_d         = err_job_q;
            state_d       = S_IDLE;
          end else begin
            row_d        = row_q + RW'(1);
            c_row_data_d = c_buf_q[row_q + RW'(1)];
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      k_len_q       <= '0;
      k_cnt_q       <= '0;
      rd_addr_q     <= '0;
      rd_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_job_q     <= 1'b0;
      a_row_q       <= '0;
      b_col_q       <= '0;
      k_first_q     <= 1'b0;
      k_last_q      <= 1'b0;
      step_valid_q  <= 1'b0;
      row_q         <= '0;
      c_row_valid_q <= 1'b0;
      c_row_data_q  <= '0;
      for (int i = 0; i < M; i++) begin
        c_buf_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      k_len_q       <= k_len_d;
      k_cnt_q       <= k_cnt_d;
      rd_addr_q     <= rd_addr_d;
      rd_en_q       <= rd_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_job_q     <= err_job_d;
      a_row_q       <= a_row_d;
      b_col_q       <= b_col_d;
      k_first_q     <= k_first_d;
      k_last_q      <= k_last_d;
      step_valid_q  <= step_valid_d;
      row_q         <= row_d;
      c_row_valid_q <= c_row_valid_d;
      c_row_data_q  <= c_row_data_d;
      c_buf_q       <= c_buf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign a_rd_en     = rd_en_q;
  assign b_rd_en     = rd_en_q;
  assign a_rd_addr   = rd_addr_q;
  assign b_rd_addr   = rd_addr_q;
  assign step_valid  = step_valid_q;
  assign a_row_flat  = a_row_q;
  assign b_col_flat  = b_col_q;
  assign k_first     = k_first_q;
  assign k_last      = k_last_q;
  assign c_row_valid = c_row_valid_q;
  assign c_row_idx   = row_q;
  assign c_row_data  = c_row_data_q;

endmodule

// File: tb/tb_os_step_feeder.sv
// Directed bench for os_step_feeder (M=N=2) with buffer/array models and
// queue scoreboards for reads, steps, result rows and done/err.
module tb_os_step_feeder;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        f;
    logic        l;
  } step_t;

  typedef struct packed {
    logic        idx;
    logic [63:0] data;
  } row_t;

  logic         clk, rst, start;
  logic [15:0]  k_len;
  logic         busy, done, err;
  logic         a_rd_en, b_rd_en;
  logic [15:0]  a_rd_addr, b_rd_addr;
  logic [63:0]  a_rd_data, b_rd_data;
  logic         step_valid, step_ready;
  logic [63:0]  a_row_flat, b_col_flat;
  logic         k_first, k_last;
  logic [127:0] c_out_flat;
  logic [3:0]   c_valid_flat;
  logic         c_row_valid, c_row_ready;
  logic [0:0]   c_row_idx;
  logic [63:0]  c_row_data;

  os_step_feeder #(.M(2), .N(2), .KW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .err(err),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .step_valid(step_valid), .step_ready(step_ready),
    .a_row_flat(a_row_flat), .b_col_flat(b_col_flat),
    .k_first(k_first), .k_last(k_last),
    .c_out_flat(c_out_flat), .c_valid_flat(c_valid_flat),
    .c_row_valid(c_row_valid), .c_row_ready(c_row_ready),
    .c_row_idx(c_row_idx), .c_row_data(c_row_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0]  a_mem [4];
  logic [63:0]  b_mem [4];
  logic [127:0] c_val;
  logic [3:0]   cv_mask;
  logic [3:0]   idle_pulse;
  logic         hold_ready;
  int           stall_len;

  int    exp_addr [$];
  step_t exp_step [$];
  row_t  exp_rows [$];
  logic  exp_done [$];
  int    jobs_exp = 0;

  int rd_cnt = 0, sv_cnt = 0, step_hs_cnt = 0, rowv_cnt = 0, done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Synchronous read buffers: data one cycle after the strobe
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr[1:0]];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr[1:0]];
  end

  // Array model: step_ready stalls after each accept; C pulse 3 cycles after the last step
  initial begin : array_model
    logic m_hs, m_last;
    int   c_wait, stall;
    c_wait = 0;
    stall = 0;
    step_ready = 1'b1;
    c_valid_flat = '0;
    c_out_flat = '0;
    forever begin
      @(negedge clk);
      m_hs = step_valid && step_ready;
      m_last = k_last;
      @(posedge clk);
      #1;
      c_valid_flat = '0;
      if (idle_pulse != 4'h0) begin
        c_out_flat = c_val;
        c_valid_flat = idle_pulse;
        idle_pulse = 4'h0;
      end
      if (c_wait > 0) begin
        c_wait--;
        if (c_wait == 0) begin
          c_out_flat = c_val;
          c_valid_flat = cv_mask;
        end
      end
      if (rst) begin
        c_wait = 0;
        stall = 0;
      end else if (m_hs) begin
        stall = stall_len;
        if (m_last) c_wait = 3;
      end
      if (hold_ready || stall > 0) begin
        step_ready = 1'b0;
        if (stall > 0) stall--;
      end else begin
        step_ready = 1'b1;
      end
    end
  end

  // Output monitor: pops scoreboard entries as the DUT produces them
  initial begin : monitor
    logic  prev_hs, prev_rd;
    step_t s;
    row_t  r;
    int    ea;
    logic  ee;
    prev_hs = 1'b0;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_hs) check("step_valid_after_hs", 64'(step_valid), 64'd0);
        if (step_valid) sv_cnt++;
        if (a_rd_en) begin
          rd_cnt++;
          check("rd_expected", 64'(exp_addr.size() > 0), 64'd1);
          check("rd_single_cycle", 64'(prev_rd), 64'd0);
          check("b_rd_en", 64'(b_rd_en), 64'd1);
          if (exp_addr.size() > 0) begin
            ea = exp_addr.pop_front();
            check("a_rd_addr", 64'(a_rd_addr), 64'(ea));
            check("b_rd_addr", 64'(b_rd_addr), 64'(ea));
          end
        end
        if (step_valid && step_ready) begin
          step_hs_cnt++;
          check("step_expected", 64'(exp_step.size() > 0), 64'd1);
          if (exp_step.size() > 0) begin
            s = exp_step.pop_front();
            check("a_row_flat", a_row_flat, s.a);
            check("b_col_flat", b_col_flat, s.b);
            check("k_first", 64'(k_first), 64'(s.f));
            check("k_last", 64'(k_last), 64'(s.l));
          end
        end
        if (c_row_valid) rowv_cnt++;
        if (c_row_valid && c_row_ready) begin
          check("row_expected", 64'(exp_rows.size() > 0), 64'd1);
          if (exp_rows.size() > 0) begin
            r = exp_rows.pop_front();
            check("c_row_idx", 64'(c_row_idx), 64'(r.idx));
            check("c_row_data", c_row_data, r.data);
          end
        end
        if (done) begin
          done_cnt++;
          check("done_expected", 64'(exp_done.size() > 0), 64'd1);
          if (exp_done.size() > 0) begin
            ee = exp_done.pop_front();
            check("done_err", 64'(err), 64'(ee));
          end
        end
      end
      prev_hs = step_valid && step_ready && !rst;
      prev_rd = a_rd_en && !rst;
    end
  end

  task automatic start_job(input int k, input logic exp_err);
    step_t s;
    row_t  r;
    for (int i = 0; i < k; i++) begin
      exp_addr.push_back(i);
      s.a = a_mem[i];
      s.b = b_mem[i];
      s.f = (i == 0);
      s.l = (i == k - 1);
      exp_step.push_back(s);
    end
    for (int i = 0; i < 2; i++) begin
      r.idx = 1'(i);
      r.data = c_val[i*64 +: 64];
      exp_rows.push_back(r);
    end
    exp_done.push_back(exp_err);
    jobs_exp++;
    start = 1'b1;
    k_len = 16'(k);
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000 && done_cnt < jobs_exp; i++) tick(1);
    check(tag, 64'(done_cnt), 64'(jobs_exp));
    tick(1);
  endtask

  initial begin : stim
    int base_hs, base_rd, base_sv, base_done, base_rowv;
    rst = 1'b1;
    start = 1'b0;
    k_len = '0;
    c_row_ready = 1'b1;
    hold_ready = 1'b0;
    stall_len = 0;
    idle_pulse = 4'h0;
    c_val = '0;
    cv_mask = 4'hF;
    a_mem[0] = 64'h40000000_3F800000;
    b_mem[0] = 64'h40800000_40400000;
    a_mem[1] = 64'h11111111_22222222;
    b_mem[1] = 64'h33333333_44444444;
    a_mem[2] = 64'h55555555_66666666;
    b_mem[2] = 64'h77777777_88888888;
    a_mem[3] = 64'h0;
    b_mem[3] = 64'h0;
    tick(3);

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_step_valid", 64'(step_valid), 64'd0);
    check("rst_c_row_valid", 64'(c_row_valid), 64'd0);
    check("rst_rd_en", 64'({a_rd_en, b_rd_en}), 64'd0);
    check("rst_flags", 64'({k_first, k_last}), 64'd0);
    check("rst_a_row", a_row_flat, 64'd0);
    check("rst_c_row_data", c_row_data, 64'd0);
    rst = 1'b0;
    tick(2);

    // K=1 outer product
    c_val = 128'h41000000_40C00000_40800000_40400000;
    base_hs = step_hs_cnt;
    start_job(1, 1'b0);
    check("busy_after_start", 64'(busy), 64'd1);
    wait_done("k1_done");
    check("k1_steps", 64'(step_hs_cnt - base_hs), 64'd1);
    check("k1_busy_clear", 64'(busy), 64'd0);

    // K=3 with 5-cycle step_ready stall after each accept
    stall_len = 5;
    c_val = 128'h0000000D_0000000C_0000000B_0000000A;
    base_hs = step_hs_cnt;
    base_rd = rd_cnt;
    start_job(3, 1'b0);
    wait_done("k3_done");
    check("k3_steps", 64'(step_hs_cnt - base_hs), 64'd3);
    check("k3_reads", 64'(rd_cnt - base_rd), 64'd3);
    stall_len = 0;

    // k_len == 0
    base_rd = rd_cnt;
    base_sv = sv_cnt;
    exp_done.push_back(1'b1);
    jobs_exp++;
    start = 1'b1;
    k_len = 16'd0;
    tick(1);
    start = 1'b0;
    check("k0_done", 64'(done), 64'd1);
    check("k0_err", 64'(err), 64'd1);
    check("k0_busy", 64'(busy), 64'd0);
    tick(1);
    check("k0_done_pulse", 64'(done), 64'd0);
    tick(3);
    check("k0_no_reads", 64'(rd_cnt - base_rd), 64'd0);
    check("k0_no_steps", 64'(sv_cnt - base_sv), 64'd0);

    // Back-pressure on result rows
    c_val = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
    c_row_ready = 1'b0;
    start_job(1, 1'b0);
    for (int i = 0; i < 200 && !c_row_valid; i++) tick(1);
    check("drain_reached", 64'(c_row_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("stall_row_idx", 64'(c_row_idx), 64'd0);
      check("stall_row_data", c_row_data, 64'hBBBB0002_AAAA0001);
      tick(1);
    end
    c_row_ready = 1'b1;
    tick(1);
    check("b2b_row1_valid", 64'(c_row_valid), 64'd1);
    check("b2b_row1_idx", 64'(c_row_idx), 64'd1);
    check("b2b_row1_data", c_row_data, 64'hDDDD0004_CCCC0003);
    tick(1);
    check("b2b_valid_drop", 64'(c_row_valid), 64'd0);
    check("b2b_done", 64'(done), 64'd1);
    wait_done("drain_done");

    // Reset while a step is offered
    hold_ready = 1'b1;
    tick(2);
    start_job(2, 1'b0);
    for (int i = 0; i < 50 && !step_valid; i++) tick(1);
    check("issue_reached", 64'(step_valid), 64'd1);
    base_done = done_cnt;
    rst = 1'b1;
    tick(1);
    check("rst_mid_step_valid", 64'(step_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    rst = 1'b0;
    hold_ready = 1'b0;
    exp_addr.delete();
    exp_step.delete();
    exp_rows.delete();
    exp_done.delete();
    jobs_exp--;
    tick(5);
    check("rst_mid_no_done", 64'(done_cnt - base_done), 64'd0);
    c_val = 128'h4_3_2_1;
    start_job(1, 1'b0);
    wait_done("post_rst_done");

    // start while busy is ignored
    stall_len = 3;
    base_hs = step_hs_cnt;
    start_job(2, 1'b0);
    tick(3);
    check("busy_mid_job", 64'(busy), 64'd1);
    start = 1'b1;
    k_len = 16'd3;
    tick(1);
    start = 1'b0;
    wait_done("busy_start_done");
    tick(10);
    check("busy_start_steps", 64'(step_hs_cnt - base_hs), 64'd2);
    check("busy_start_idle", 64'(busy), 64'd0);
    stall_len = 0;

    // c_valid pulse while idle
    base_rowv = rowv_cnt;
    base_done = done_cnt;
    c_val = 128'hFFFF;
    idle_pulse = 4'hF;
    tick(5);
    check("idle_cv_busy", 64'(busy), 64'd0);
    check("idle_cv_rowv", 64'(rowv_cnt - base_rowv), 64'd0);
    check("idle_cv_done", 64'(done_cnt - base_done), 64'd0);

    // Partial c_valid pulse flags err
    c_val = 128'h00000008_00000007_00000006_00000005;
    cv_mask = 4'b0111;
    start_job(2, 1'b1);
    wait_done("partial_done");
    cv_mask = 4'hF;

    check("left_addr", 64'(exp_addr.size()), 64'd0);
    check("left_steps", 64'(exp_step.size()), 64'd0);
    check("left_rows", 64'(exp_rows.size()), 64'd0);
    check("left_done", 64'(exp_done.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
